// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display update path.
package seven_seg_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int NUM_DIGITS_DEF = 6;
  localparam int BCD_MAX        = 999_999;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE,
    HOLD
  } ctrl_state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble correction step: every BCD nibble >= 5 gets +3 before the shift.
module bcd_dabble_step
  import seven_seg_pkg::*;
#(
  parameter int NUM_NIBBLES = NUM_DIGITS_DEF + 1
) (
  input  logic [NUM_NIBBLES*4-1:0] acc,
  output logic [NUM_NIBBLES*4-1:0] corrected
);

  always_comb begin
    corrected = acc;
    for (int unsigned i = 0; i < NUM_NIBBLES; i++) begin
      if (acc[i*4 +: 4] >= 4'd5) begin
        corrected[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
      end
    end
  end

endmodule

// File: rtl/seg_display_update_ctrl.sv
// Accepts binary values, converts them to BCD one bit per clock and publishes
// rate-limited digit/blank/overflow updates for the segment decoders.
module seg_display_update_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DATA_W      = 20,
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int HOLD_CYCLES = 5_000_000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  input  logic [DATA_W-1:0]                 in_data,
  output logic                              in_ready,
  input  logic                              blank_lz_en,
  output bcd_digit_t [NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]             digit_blank,
  output logic                              overflow,
  output logic                              update_strobe,
  output logic                              busy
);

  localparam int ACC_W  = (NUM_DIGITS + 1) * 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  ctrl_state_t state, state_next;

  logic [DATA_W-1:0]        bin;
  logic [ACC_W-1:0]         acc;
  logic [ACC_W-1:0]         corrected;
  logic [ACC_W+DATA_W-1:0]  shifted;
  logic [CNT_W-1:0]         bit_cnt;
  logic [HOLD_W-1:0]        hold_cnt;
  logic                     blank_lz;

  bcd_digit_t [NUM_DIGITS-1:0] res_digits;
  logic [NUM_DIGITS-1:0]       res_blank;
  logic                        res_ovf;
  logic                        all_zero;
  int unsigned                 idx;

  bcd_dabble_step #(
    .NUM_NIBBLES(NUM_DIGITS + 1)
  ) u_step (
    .acc      (acc),
    .corrected(corrected)
  );

  assign shifted  = {corrected, bin} << 1;
  assign in_ready = (state == IDLE);
  assign busy     = (state == CONVERT) || (state == HOLD);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = CONVERT;
      CONVERT: if (bit_cnt == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = (HOLD_CYCLES == 0) ? IDLE : HOLD;
      // HOLD leaves only after the counter has been observed at zero
      HOLD:    if (hold_cnt == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result formatting from the finished accumulator, scanning MSD downwards for blanking
  always_comb begin
    res_ovf   = (acc[ACC_W-1 -: 4] != 4'd0);
    res_blank = '0;
    all_zero  = 1'b1;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      res_digits[i] = res_ovf ? 4'd9 : acc[i*4 +: 4];
    end
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      idx            = NUM_DIGITS - k;
      all_zero       = all_zero & (acc[idx*4 +: 4] == 4'd0);
      res_blank[idx] = blank_lz & all_zero & ~res_ovf;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bin           <= '0;
      acc           <= '0;
      bit_cnt       <= '0;
      hold_cnt      <= '0;
      blank_lz      <= 1'b0;
      digits        <= '0;
      digit_blank   <= '0;
      overflow      <= 1'b0;
      update_strobe <= 1'b0;
    end else begin
      state         <= state_next;
      update_strobe <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            bin      <= in_data;
            acc      <= '0;
            bit_cnt  <= CNT_W'(DATA_W);
            blank_lz <= blank_lz_en;
          end
        end
        CONVERT: begin
          {acc, bin} <= shifted;
          bit_cnt    <= bit_cnt - CNT_W'(1);
        end
        DONE: begin
          digits        <= res_digits;
          digit_blank   <= res_blank;
          overflow      <= res_ovf;
          update_strobe <= 1'b1;
          hold_cnt      <= HOLD_W'(HOLD_CYCLES);
        end
        HOLD: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_display_update_ctrl.sv
// Directed scoreboard bench: one DUT with a short hold, one with no hold.
module tb_seg_display_update_ctrl;

  localparam int DATA_W = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid4 = 1'b0;
  logic valid0 = 1'b0;
  logic blank_lz_en = 1'b0;
  logic [DATA_W-1:0] in_data = '0;

  logic            rdy4, ovf4, stb4, busy4;
  logic [5:0][3:0] digits4;
  logic [5:0]      blank4;
  logic            rdy0, ovf0, stb0, busy0;
  logic [5:0][3:0] digits0;
  logic [5:0]      blank0;

  seg_display_update_ctrl #(
    .DATA_W(DATA_W), .NUM_DIGITS(6), .HOLD_CYCLES(4)
  ) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(valid4), .in_data(in_data),
    .in_ready(rdy4), .blank_lz_en(blank_lz_en), .digits(digits4),
    .digit_blank(blank4), .overflow(ovf4), .update_strobe(stb4), .busy(busy4)
  );

  seg_display_update_ctrl #(
    .DATA_W(DATA_W), .NUM_DIGITS(6), .HOLD_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(valid0), .in_data(in_data),
    .in_ready(rdy0), .blank_lz_en(blank_lz_en), .digits(digits0),
    .digit_blank(blank0), .overflow(ovf0), .update_strobe(stb0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned stb4_cnt = 0;
  int unsigned last4 = 0;

  typedef struct packed {
    logic [23:0] d;
    logic [5:0]  b;
    logic        o;
  } exp_t;

  exp_t q4[$];
  exp_t q0[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned v, input logic blz);
    exp_t e;
    int unsigned x;
    bit nz_above;
    e = '0;
    x = v;
    nz_above = 1'b0;
    if (v > 999_999) begin
      e.o = 1'b1;
      e.d = {6{4'd9}};
      e.b = '0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        e.d[i*4 +: 4] = 4'(x % 10);
        x = x / 10;
      end
      for (int unsigned k = 1; k < 6; k++) begin
        nz_above = nz_above | (e.d[(6-k)*4 +: 4] != 4'd0);
        e.b[6-k] = blz & ~nz_above;
      end
    end
    return e;
  endfunction

  task automatic score(input bit sel, input logic [23:0] d, input logic [5:0] b, input logic o);
    exp_t e;
    int unsigned sz;
    sz = sel ? q0.size() : q4.size();
    check(sel ? "pending0" : "pending4", 32'(sz > 0), 32'd1);
    if (sz == 0) return;
    e = sel ? q0.pop_front() : q4.pop_front();
    check(sel ? "digits0" : "digits4", 32'(d), 32'(e.d));
    check(sel ? "blank0" : "blank4", 32'(b), 32'(e.b));
    check(sel ? "ovf0" : "ovf4", 32'(o), 32'(e.o));
  endtask

  always @(negedge clk) begin
    if (reset_n && stb4) begin
      stb4_cnt++;
      last4 = cyc;
      score(1'b0, digits4, blank4, ovf4);
    end
    if (reset_n && stb0) score(1'b1, digits0, blank0, ovf0);
  end

  // Presents a value, waits for acceptance, returns the edge count of the transfer.
  task automatic send(input bit sel, input int unsigned v, input logic blz, output int unsigned t);
    int unsigned g;
    g = 0;
    @(negedge clk);
    in_data = DATA_W'(v);
    blank_lz_en = blz;
    if (sel) valid0 = 1'b1; else valid4 = 1'b1;
    while (!(sel ? rdy0 : rdy4) && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("accept_timeout", 32'(g < 200), 32'd1);
    if (sel) q0.push_back(model(v, blz)); else q4.push_back(model(v, blz));
    @(posedge clk);
    #1;
    t = cyc;
  endtask

  task automatic drain(input bit sel);
    int unsigned g;
    g = 0;
    while ((sel ? q0.size() : q4.size()) != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("drain", sel ? q0.size() : q4.size(), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t, t2, t3, s;

    reset_n = 1'b0;
    #12;
    check("rst_ready", 32'(rdy4), 32'd1);
    check("rst_digits", 32'(digits4), 32'd0);
    check("rst_blank", 32'(blank4), 32'd0);
    check("rst_ovf", 32'(ovf4), 32'd0);
    check("rst_strobe", 32'(stb4), 32'd0);
    check("rst_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // basic conversion and latency
    s = stb4_cnt;
    send(1'b0, 123456, 1'b0, t);
    valid4 = 1'b0;
    check("busy_convert", 32'(busy4), 32'd1);
    check("ready_convert", 32'(rdy4), 32'd0);
    drain(1'b0);
    check("latency", last4 - t, 32'd21);
    check("strobes_t1", stb4_cnt - s, 32'd1);

    // leading-zero blanking
    send(1'b0, 42, 1'b1, t);
    valid4 = 1'b0;
    drain(1'b0);
    send(1'b0, 0, 1'b1, t);
    valid4 = 1'b0;
    drain(1'b0);

    // overflow and the largest displayable value
    send(1'b0, 1048575, 1'b1, t);
    valid4 = 1'b0;
    drain(1'b0);
    send(1'b0, 999999, 1'b0, t);
    valid4 = 1'b0;
    drain(1'b0);

    // valid held through the busy window
    s = stb4_cnt;
    send(1'b0, 7, 1'b0, t);
    send(1'b0, 8, 1'b0, t2);
    valid4 = 1'b0;
    check("accept_spacing", t2 - t, 32'd27);
    drain(1'b0);
    repeat (8) @(negedge clk);
    check("strobes_t4", stb4_cnt - s, 32'd2);

    // asynchronous reset mid-conversion
    send(1'b0, 555, 1'b0, t);
    valid4 = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("busy_before_rst", 32'(busy4), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_ready", 32'(rdy4), 32'd1);
    check("arst_digits", 32'(digits4), 32'd0);
    check("arst_blank", 32'(blank4), 32'd0);
    check("arst_ovf", 32'(ovf4), 32'd0);
    check("arst_busy", 32'(busy4), 32'd0);
    q4.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(1'b0, 17, 1'b0, t);
    valid4 = 1'b0;
    drain(1'b0);

    // no-hold instance, back-to-back
    send(1'b1, 1, 1'b0, t);
    send(1'b1, 2, 1'b0, t2);
    send(1'b1, 3, 1'b0, t3);
    valid0 = 1'b0;
    check("b2b_gap_a", t2 - t, 32'd22);
    check("b2b_gap_b", t3 - t2, 32'd22);
    drain(1'b1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
